// File: rtl/score_tracker.sv
// Rhythm-game score tracker: accumulates judged hits for one song and reports progress to the scorer.
// Optional health/fail mechanics are enabled by defining SCORE_HEALTH_EN.
module score_tracker #(
    parameter int TOTAL_W = 24,
    parameter int HP_MAX  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [20:0]        total_note,
    input  logic [1:0]         mod,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [20:0]        base_score,
    input  logic [20:0]        bonus_score,
    input  logic [20:0]        combo,
    input  logic [2:0]         level,
    output logic [20:0]        last_combo,
    output logic [20:0]        last_base_score,
    output logic [20:0]        now_cnt,
    output logic [TOTAL_W-1:0] total_score,
    output logic [20:0]        max_combo,
    output logic [2:0]         final_level,
    output logic [10:0]        hp,
    output logic               done,
    output logic               failed,
    output logic [1:0]         state_dbg
);
    // Handshake: a hit transfers on a rising edge where hit_valid && hit_ready and abort is low;
    // hit_ready depends only on the FSM state, never on the inputs.

    typedef enum logic [1:0] {IDLE, PLAY, DONE, FAIL} state_t;

    localparam logic [10:0] HP_INIT = 11'(HP_MAX);
    localparam int          SW      = ((TOTAL_W > 22) ? TOTAL_W : 22) + 1;

    state_t      state_q, state_d;
    logic        clear, accept, hp_fail, last_hit;
    logic [20:0] total_note_q;
    logic [21:0] lb_sum;
    logic [SW-1:0] tot_sum;

    assign hit_ready = (state_q == PLAY);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;
    assign last_hit  = ((now_cnt + 21'd1) == total_note_q);
    assign lb_sum    = {1'b0, last_base_score} + {1'b0, base_score};
    assign tot_sum   = SW'(total_score) + SW'(base_score) + SW'(bonus_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // abort has priority over both start and a presented hit.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort && (total_note != '0)) begin
                    state_d = PLAY;
                    clear   = 1'b1;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hit_valid) begin
                    accept = 1'b1;
                    if (hp_fail)       state_d = FAIL;
                    else if (last_hit) state_d = DONE;
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start && (total_note != '0)) begin
                    state_d = PLAY;
                    clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_note_q    <= '0;
            now_cnt         <= '0;
            last_combo      <= '0;
            last_base_score <= '0;
            total_score     <= '0;
            max_combo       <= '0;
            final_level     <= 3'd6;
        end else if (clear) begin
            total_note_q    <= total_note;
            now_cnt         <= '0;
            last_combo      <= '0;
            last_base_score <= '0;
            total_score     <= '0;
            max_combo       <= '0;
            final_level     <= 3'd6;
        end else if (accept) begin
            now_cnt         <= now_cnt + 21'd1;
            last_combo      <= combo;
            last_base_score <= lb_sum[21] ? '1 : lb_sum[20:0];
            total_score     <= (tot_sum > SW'({TOTAL_W{1'b1}})) ? '1 : tot_sum[TOTAL_W-1:0];
            max_combo       <= (combo > max_combo) ? combo : max_combo;
            final_level     <= level;
        end
    end

`ifdef SCORE_HEALTH_EN
    logic [1:0]  mod_q;
    logic [11:0] hp_up;
    logic [10:0] hp_acc;

    assign hp_up   = {1'b0, hp} + 12'd20;
    // No Fail mode (01) lets hp sit at zero without ending the song.
    assign hp_fail = (hp_acc == '0) && (mod_q != 2'b01);
    assign failed  = (state_q == FAIL);

    always_comb begin
        hp_acc = hp;
        if (base_score == '0) hp_acc = (hp < 11'd100) ? 11'd0 : hp - 11'd100;
        else                  hp_acc = (hp_up > {1'b0, HP_INIT}) ? HP_INIT : hp_up[10:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp    <= HP_INIT;
            mod_q <= 2'b00;
        end else if (clear) begin
            hp    <= HP_INIT;
            mod_q <= mod;
        end else if (accept) begin
            hp    <= hp_acc;
        end
    end
`else
    logic unused_mod;

    assign unused_mod = ^mod;
    assign hp         = HP_INIT;
    assign hp_fail    = 1'b0;
    assign failed     = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_score_tracker;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;
`ifdef SCORE_HEALTH_EN
    localparam int HEALTH_ON = 1;
`else
    localparam int HEALTH_ON = 0;
`endif

    typedef struct packed {
        logic [1:0]  st;
        logic        rdy;
        logic        dn;
        logic        fl;
        logic [20:0] now;
        logic [20:0] lb;
        logic [20:0] lc;
        logic [20:0] mc;
        logic [23:0] tot;
        logic [7:0]  tot8;
        logic [10:0] hp;
        logic [2:0]  lvl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, hit_valid;
    logic [20:0] total_note, base_score, bonus_score, combo;
    logic [1:0]  mod;
    logic [2:0]  level;

    logic        hit_ready, done, failed;
    logic [20:0] last_combo, last_base_score, now_cnt, max_combo;
    logic [23:0] total_score;
    logic [2:0]  final_level;
    logic [10:0] hp;
    logic [1:0]  state_dbg;

    logic        u8_ready, u8_done, u8_failed;
    logic [20:0] u8_lc, u8_lb, u8_now, u8_mc;
    logic [7:0]  u8_total;
    logic [2:0]  u8_lvl;
    logic [10:0] u8_hp;
    logic [1:0]  u8_state;

    exp_t  exp_q[$];
    string name_q[$];
    logic  probe = 1'b0;
    logic  probe_seen = 1'b0;
    logic  hs_seen = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    score_tracker #(.TOTAL_W(24), .HP_MAX(1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .total_note(total_note), .mod(mod), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .base_score(base_score), .bonus_score(bonus_score), .combo(combo), .level(level),
        .last_combo(last_combo), .last_base_score(last_base_score), .now_cnt(now_cnt),
        .total_score(total_score), .max_combo(max_combo), .final_level(final_level),
        .hp(hp), .done(done), .failed(failed), .state_dbg(state_dbg)
    );

    score_tracker #(.TOTAL_W(8), .HP_MAX(1000)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .total_note(total_note), .mod(mod), .hit_valid(hit_valid), .hit_ready(u8_ready),
        .base_score(base_score), .bonus_score(bonus_score), .combo(combo), .level(level),
        .last_combo(u8_lc), .last_base_score(u8_lb), .now_cnt(u8_now),
        .total_score(u8_total), .max_combo(u8_mc), .final_level(u8_lvl),
        .hp(u8_hp), .done(u8_done), .failed(u8_failed), .state_dbg(u8_state)
    );

    function automatic exp_t mk(input logic [1:0] st, input int now, input int lb, input int lc,
                                input int mc, input int tot, input int tot8, input int hpv,
                                input int lvl);
        exp_t e;
        e.st   = st;
        e.rdy  = (st == S_PLAY);
        e.dn   = (st == S_DONE);
        e.fl   = (st == S_FAIL);
        e.now  = 21'(now);
        e.lb   = 21'(lb);
        e.lc   = 21'(lc);
        e.mc   = 21'(mc);
        e.tot  = 24'(tot);
        e.tot8 = 8'(tot8);
        e.hp   = 11'(hpv);
        e.lvl  = 3'(lvl);
        return e;
    endfunction

    // Monitor: a probe or a handshake at a rising edge produces one observation at the next falling edge.
    always @(posedge clk) begin
        probe_seen = probe;
        hs_seen    = hit_valid && hit_ready;
    end

    always @(negedge clk) begin
        exp_t  a, e;
        string nm;
        if (probe_seen || hs_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got observation with state=%0d, required none", state_dbg);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.st = state_dbg;  a.rdy = hit_ready; a.dn = done; a.fl = failed;
                a.now = now_cnt;   a.lb = last_base_score; a.lc = last_combo; a.mc = max_combo;
                a.tot = total_score; a.tot8 = u8_total; a.hp = hp; a.lvl = final_level;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got st=%0d rdy=%0b dn=%0b fl=%0b now=%0d lb=%0d lc=%0d mc=%0d tot=%0d tot8=%0d hp=%0d lvl=%0d; required st=%0d rdy=%0b dn=%0b fl=%0b now=%0d lb=%0d lc=%0d mc=%0d tot=%0d tot8=%0d hp=%0d lvl=%0d",
                             nm, a.st, a.rdy, a.dn, a.fl, a.now, a.lb, a.lc, a.mc, a.tot, a.tot8, a.hp, a.lvl,
                             e.st, e.rdy, e.dn, e.fl, e.now, e.lb, e.lc, e.mc, e.tot, e.tot8, e.hp, e.lvl);
                end
            end
        end
    end

    task automatic cycle(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic do_start(input int tn, input logic [1:0] m, input string nm, input exp_t e);
        start = 1'b1; total_note = 21'(tn); mod = m;
        cycle(nm, e);
        start = 1'b0;
    endtask

    task automatic do_hit(input int b, input int bo, input int c, input int l, input string nm, input exp_t e);
        hit_valid = 1'b1; base_score = 21'(b); bonus_score = 21'(bo); combo = 21'(c); level = 3'(l);
        cycle(nm, e);
        hit_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hit_valid = 1'b0;
        total_note = '0; mod = '0; base_score = '0; bonus_score = '0; combo = '0; level = '0;
        @(negedge clk);
        cycle("reset", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 1000, 6));
        rst_n = 1'b1;

        do_start(0, 2'b00, "start_zero", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 1000, 6));
        do_start(3, 2'b00, "start", mk(S_PLAY, 0, 0, 0, 0, 0, 0, 1000, 6));
        // Mid-song changes of total_note/mod must be ignored.
        total_note = 21'd1; mod = 2'b11;
        do_hit(100, 10, 2, 1, "hit1", mk(S_PLAY, 1, 100, 2, 2, 110, 110, 1000, 1));
        do_hit(200, 20, 4, 0, "hit2", mk(S_PLAY, 2, 300, 4, 4, 330, 255, 1000, 0));
        do_hit(0, 0, 0, 6, "hit3_done", mk(S_DONE, 3, 300, 0, 4, 330, 255, HEALTH_ON ? 900 : 1000, 6));
        do_hit(50, 5, 9, 2, "drop_in_done", mk(S_DONE, 3, 300, 0, 4, 330, 255, HEALTH_ON ? 900 : 1000, 6));

        do_start(8, 2'b00, "restart", mk(S_PLAY, 0, 0, 0, 0, 0, 0, 1000, 6));
        do_hit(200, 0, 1, 2, "sat_a", mk(S_PLAY, 1, 200, 1, 1, 200, 200, 1000, 2));
        do_hit(200, 0, 1, 2, "sat_b", mk(S_PLAY, 2, 400, 1, 1, 400, 255, 1000, 2));
        do_hit(2097000, 0, 3, 3, "lb_sat", mk(S_PLAY, 3, 2097151, 3, 3, 2097400, 255, 1000, 3));
        do_hit(1, 1, 2, 4, "combo_drop", mk(S_PLAY, 4, 2097151, 2, 3, 2097402, 255, 1000, 4));
        do_hit(1, 0, 5, 5, "combo_max", mk(S_PLAY, 5, 2097151, 5, 5, 2097403, 255, 1000, 5));

        abort = 1'b1; start = 1'b1;
        do_hit(1, 1, 9, 0, "abort_hit", mk(S_IDLE, 5, 2097151, 5, 5, 2097403, 255, 1000, 5));
        abort = 1'b0; start = 1'b0;
        do_hit(1, 1, 9, 0, "drop_in_idle", mk(S_IDLE, 5, 2097151, 5, 5, 2097403, 255, 1000, 5));

        do_start(10, 2'b00, "start_rst", mk(S_PLAY, 0, 0, 0, 0, 0, 0, 1000, 6));
        for (int k = 1; k <= 7; k++)
            do_hit(10, 0, k, 1, $sformatf("run_%0d", k), mk(S_PLAY, k, 10*k, k, k, 10*k, 10*k, 1000, 1));
        // Reset arrives while a hit is being presented.
        hit_valid = 1'b1; base_score = 21'd50; combo = 21'd8; level = 3'd2;
        rst_n = 1'b0;
        cycle("mid_reset", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 1000, 6));
        hit_valid = 1'b0;
        rst_n = 1'b1;

`ifdef SCORE_HEALTH_EN
        do_start(20, 2'b00, "hp_start", mk(S_PLAY, 0, 0, 0, 0, 0, 0, 1000, 6));
        for (int k = 1; k <= 10; k++)
            do_hit(0, 0, 0, 6, $sformatf("miss_%0d", k),
                   mk((k == 10) ? S_FAIL : S_PLAY, k, 0, 0, 0, 0, 0, 1000 - 100*k, 6));
        do_start(20, 2'b01, "nofail_start", mk(S_PLAY, 0, 0, 0, 0, 0, 0, 1000, 6));
        for (int k = 1; k <= 11; k++)
            do_hit(0, 0, 0, 6, $sformatf("nofail_miss_%0d", k),
                   mk(S_PLAY, k, 0, 0, 0, 0, 0, (k >= 10) ? 0 : 1000 - 100*k, 6));
`endif

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter TOTAL_W, 24, width of total_score.
REQ-002 SHALL have parameter HP_MAX, 1000, starting and maximum health.
REQ-003 SHALL have port clk  in  1  system clock, all state rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  in  1  begin song; latches total_note and mod.
REQ-006 SHALL have port abort  in  1  abandon song, return to IDLE.
REQ-007 SHALL have port total_note  in  21  notes in chart.
REQ-008 SHALL have port mod  in  2  game mode (00 Normal, 01 No Fail, 10 Half Time, 11 Double Time).
REQ-009 SHALL have port hit_valid  in  1  judged hit presented by scorer.
REQ-010 SHALL have port hit_ready  out  1  tracker accepts hit this cycle.
REQ-011 SHALL have ports base_score, bonus_score, combo  in  21 each  scorer results for the hit.
REQ-012 SHALL have port level  in  3  scorer grade for the hit (0 best … 6 worst).
REQ-013 SHALL have ports last_combo, last_base_score, now_cnt  out  21 each  feedback to scorer.
REQ-014 SHALL have ports total_score out TOTAL_W, max_combo out 21, final_level out 3, hp out 11, done out 1, failed out 1.

Function
REQ-015 SHALL implement FSM states IDLE, PLAY, DONE, FAIL.
REQ-016 IDLE: start with total_note≠0 -> PLAY, clearing all accumulators, hp=HP_MAX; start with total_note=0 ignored.
REQ-017 PLAY: hit_ready=1; hit_ready=0 in all other states.
REQ-018 Hit accepted when hit_valid&&hit_ready; all outputs update on that same edge (one-cycle latency, no buffering).
REQ-019 On accept: now_cnt+=1; last_combo=combo; last_base_score+=base_score saturating at 2^21-1; total_score+=base_score+bonus_score saturating at 2^TOTAL_W-1; max_combo=max(max_combo,combo); final_level=level.
REQ-020 Accept making now_cnt equal latched total_note -> DONE, done=1 while in DONE.
REQ-021 hit_valid outside PLAY SHALL be dropped with no state change.
REQ-022 abort in PLAY -> IDLE, accumulators hold; abort coincident with hit_valid: abort wins, hit dropped.
REQ-023 start in DONE or FAIL -> PLAY with full clear; start in PLAY ignored; start and abort together: abort wins.
REQ-024 Mid-song change of total_note or mod inputs SHALL have no effect (latched values used).
REQ-025 Arithmetic unsigned; sums computed at width+1 before saturation, no wrap-around.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, hp=HP_MAX, final_level=6, every other output 0.
REQ-027 Reset mid-PLAY SHALL discard the in-flight hit.

Configuration
REQ-028 Macro SCORE_HEALTH_EN defined: on accept, base_score=0 gives hp-=100 floored at 0, else hp+=20 capped at HP_MAX; hp reaching 0 with latched mod≠01 -> FAIL (failed=1, hit_ready=0); mod=01 clamps at 0 without failing.
REQ-029 SCORE_HEALTH_EN undefined: hp constant HP_MAX, failed constant 0, FAIL unreachable.
REQ-030 Hit that both reaches total_note and empties hp SHALL go to FAIL.

Verification
REQ-031 Reset, start, total_note=3, hits (base,bonus,combo)=(100,10,2),(200,20,4),(0,0,0) -> total_score=330, last_base_score=300, max_combo=4, now_cnt=3, DONE.
REQ-032 TOTAL_W=8, two hits base=200,bonus=0 -> total_score=255 saturated.
REQ-033 SCORE_HEALTH_EN, mod=00, 10 misses -> hp=0, FAIL after 10th; mod=01 same -> hp=0, stays PLAY.
REQ-034 hit_valid and abort same cycle in PLAY, now_cnt=5 -> IDLE, now_cnt=5.
REQ-035 Assert rst_n low mid-song with now_cnt=7 -> immediate IDLE, now_cnt=0, hp=1000, final_level=6.
REQ-036 Start with total_note=0 -> remains IDLE, hit_ready=0.
